// File: rtl/fft8_pkg.sv
// Shared constants, bank-state encoding and bit-reverse helper for the 8-point FFT
// output reorder path.
package fft8_pkg;

  localparam int DW_DEF = 32;
  localparam int N      = 8;
  localparam int LOG2N  = 3;

  typedef enum logic [1:0] {
    BANK_FILL  = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_DRAIN = 2'd2
  } bank_state_e;

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] k);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = k[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft8_reorder_out_if.sv
// Butterfly-pair input and natural-order sample output of fft8_reorder_out.
// master = producer/consumer environment, slave = the reorder block.
interface fft8_reorder_out_if
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEF
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_idx;
  logic [DW-1:0]        in_a;
  logic [DW-1:0]        in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [LOG2N-1:0]     out_idx;
  logic                 out_last;
  logic                 dup_err;

  modport master (
    output in_valid, in_idx, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, dup_err
  );

  modport slave (
    input  in_valid, in_idx, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, dup_err
  );

endinterface

// File: rtl/fft8_reorder_bank.sv
// One 8-sample reorder bank: storage addressed {idx,lsb}, a 4-bit pair fill mask and
// the FILL/FULL/DRAIN life cycle of the frame it holds.
module fft8_reorder_bank
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_idx_i,
  input  logic [DW-1:0]    wr_a_i,
  input  logic [DW-1:0]    wr_b_i,
  input  logic             rd_sel_i,
  input  logic             release_i,
  input  logic [LOG2N-1:0] rd_addr_i,
  output bank_state_e      state_o,
  output logic [3:0]       mask_o,
  output logic [DW-1:0]    rd_data_o
);

  bank_state_e   state_q, state_d;
  logic [3:0]    mask_q, mask_d;
  logic [3:0]    wr_oh;
  logic [DW-1:0] mem_q [N];

  assign wr_oh = 4'b0001 << wr_idx_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BANK_FILL;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
    end
  end

  // Storage carries no reset: a discarded frame is simply overwritten later.
  always_ff @(posedge clk) begin
    if (wr_en_i && (state_q == BANK_FILL)) begin
      mem_q[{wr_idx_i, 1'b0}] <= wr_a_i;
      mem_q[{wr_idx_i, 1'b1}] <= wr_b_i;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    unique case (state_q)
      BANK_FILL: begin
        if (wr_en_i) begin
          mask_d = mask_q | wr_oh;
          if ((mask_q | wr_oh) == 4'hF) begin
            state_d = BANK_FULL;
          end
        end
      end
      BANK_FULL: begin
        if (release_i) begin
          state_d = BANK_FILL;
          mask_d  = '0;
        end else if (rd_sel_i) begin
          state_d = BANK_DRAIN;
        end
      end
      BANK_DRAIN: begin
        if (release_i) begin
          state_d = BANK_FILL;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = BANK_FILL;
        mask_d  = '0;
      end
    endcase
  end

  always_comb begin
    state_o   = state_q;
    mask_o    = mask_q;
    rd_data_o = mem_q[rd_addr_i];
  end

endmodule

// File: rtl/fft8_reorder_out.sv
// Reorders bit-reversed final-stage butterfly pairs of an 8-point FFT into natural bin
// order. FFT8_REORDER_PINGPONG_EN selects two banks (fill overlaps drain); default is one.
module fft8_reorder_out
  import fft8_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fft8_reorder_out_if.slave        bus
);

`ifdef FFT8_REORDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  bank_state_e      bank_st   [NB];
  logic [3:0]       bank_mask [NB];
  logic [DW-1:0]    bank_rd   [NB];
  logic [NB-1:0]    bank_we;
  logic [NB-1:0]    bank_sel;
  logic [NB-1:0]    bank_rel;

  bank_state_e      wr_st;
  bank_state_e      rd_st;
  logic [3:0]       wr_mask;
  logic [DW-1:0]    rd_data;
  logic [3:0]       idx_oh;
  logic             in_ready_w;
  logic             accept;
  logic             complete;
  logic             out_valid_w;
  logic             out_hs;
  logic             last_hs;
  logic [LOG2N-1:0] rd_addr;

  logic [LOG2N-1:0] k_q, k_d;
  logic             dup_q, dup_d;
`ifdef FFT8_REORDER_PINGPONG_EN
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
`endif

  for (genvar b = 0; b < NB; b++) begin : g_bank
    fft8_reorder_bank #(.DW(DW)) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en_i   (bank_we[b]),
      .wr_idx_i  (bus.in_idx),
      .wr_a_i    (bus.in_a),
      .wr_b_i    (bus.in_b),
      .rd_sel_i  (bank_sel[b]),
      .release_i (bank_rel[b]),
      .rd_addr_i (rd_addr),
      .state_o   (bank_st[b]),
      .mask_o    (bank_mask[b]),
      .rd_data_o (bank_rd[b])
    );
  end

  // Write/read bank views; a single bank serves both sides.
  always_comb begin
`ifdef FFT8_REORDER_PINGPONG_EN
    wr_st   = bank_st[wr_ptr_q];
    wr_mask = bank_mask[wr_ptr_q];
    rd_st   = bank_st[rd_ptr_q];
    rd_data = bank_rd[rd_ptr_q];
`else
    wr_st   = bank_st[0];
    wr_mask = bank_mask[0];
    rd_st   = bank_st[0];
    rd_data = bank_rd[0];
`endif
  end

  always_comb begin
    idx_oh      = 4'b0001 << bus.in_idx;
    in_ready_w  = (wr_st == BANK_FILL);
    accept      = bus.in_valid && in_ready_w;
    complete    = accept && ((wr_mask | idx_oh) == 4'hF);
    out_valid_w = (rd_st != BANK_FILL);
    out_hs      = out_valid_w && bus.out_ready;
    last_hs     = out_hs && (k_q == 3'd7);
    rd_addr     = bit_rev(k_q);
    k_d         = out_hs ? k_q + 3'd1 : k_q;
    dup_d       = accept && wr_mask[bus.in_idx];
  end

  always_comb begin
`ifdef FFT8_REORDER_PINGPONG_EN
    wr_ptr_d = wr_ptr_q ^ complete;
    rd_ptr_d = rd_ptr_q ^ last_hs;
    for (int b = 0; b < NB; b++) begin
      bank_we[b]  = accept && (wr_ptr_q == 1'(b));
      bank_sel[b] = (rd_ptr_q == 1'(b));
      bank_rel[b] = last_hs && (rd_ptr_q == 1'(b));
    end
`else
    bank_we[0]  = accept;
    bank_sel[0] = 1'b1;
    bank_rel[0] = last_hs;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q      <= '0;
      dup_q    <= 1'b0;
`ifdef FFT8_REORDER_PINGPONG_EN
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
`endif
    end else begin
      k_q      <= k_d;
      dup_q    <= dup_d;
`ifdef FFT8_REORDER_PINGPONG_EN
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
`endif
    end
  end

  // Output fields are read straight from the held bank, so they stay put while stalled.
  always_comb begin
    bus.in_ready  = in_ready_w;
    bus.out_valid = out_valid_w;
    bus.out_data  = out_valid_w ? rd_data : '0;
    bus.out_idx   = k_q;
    bus.out_last  = out_valid_w && (k_q == 3'd7);
    bus.dup_err   = dup_q;
  end

endmodule

// File: doc/fft8_reorder_out.md
FFT8_REORDER_OUT -- requirements
Module: fft8_reorder_out

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning width of one packed complex posit sample (real upper DW/2 bits, imag lower DW/2 bits).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  butterfly result pair presented.
REQ-005 in_ready  output  1  block can accept a pair this cycle.
REQ-006 in_idx  input  2  final-stage butterfly index 0..3 of the pair.
REQ-007 in_a  input  DW  butterfly upper output (result1).
REQ-008 in_b  input  DW  butterfly lower output (result2).
REQ-009 out_valid  output  1  out_data holds a sample.
REQ-010 out_ready  input  1  downstream accepts the sample.
REQ-011 out_data  output  DW  sample in natural frequency order.
REQ-012 out_idx  output  3  frequency bin k of out_data.
REQ-013 out_last  output  1  high with bin 7.
REQ-014 dup_err  output  1  one-cycle pulse on duplicate in_idx within a frame.

Function
REQ-015 Accept on in_valid && in_ready: in_a written to bank address {in_idx,0}, in_b to {in_idx,1}; in_idx bit set in bank fill mask.
REQ-016 Pairs within a frame SHALL be accepted in any in_idx order.
REQ-017 Duplicate in_idx in a frame SHALL overwrite the stored pair and pulse dup_err the following cycle; frame still needs all four distinct indices.
REQ-018 Bank states: FILL (mask incomplete), FULL (mask = 4'b1111, awaiting drain), DRAIN (emitting); FILL->FULL on accept completing mask; FULL->DRAIN when bank selected for read; DRAIN->FILL after bin 7 handshake, mask cleared.
REQ-019 Read counter k runs 0..7; read address = bit-reverse(k); out_idx = k.
REQ-020 out_valid SHALL assert the cycle after the completing accept (latency 1) when read side idle.
REQ-021 out_data/out_idx/out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 Output SHALL sustain one sample per cycle under continuous out_ready.
REQ-023 in_ready SHALL be high iff the write bank is in FILL.
REQ-024 Banks drained in completion order; write pointer toggles on frame completion, read pointer toggles after bin 7.
REQ-025 Simultaneous last output handshake and completing input accept SHALL both take effect in that cycle with no bubble on output.

Reset
REQ-026 On rst_n low: both banks FILL, masks 0, pointers 0, k = 0, in_ready = 1, out_valid = 0, out_last = 0, out_idx = 0, out_data = 0, dup_err = 0.
REQ-027 Reset mid-frame SHALL discard all partial and full frames; storage contents need not clear.

Configuration
REQ-028 Macro FFT8_REORDER_PINGPONG_EN defined: two 8-entry banks as above, fill overlaps drain.
REQ-029 Macro undefined: single 8-entry bank; in_ready low from frame completion until bin 7 handshake completes.

Structure
REQ-030 Shared package fft8_pkg SHALL hold DW default, N=8, log2 constant, bank-state enum, bit-reverse function.
REQ-031 One sub-module, fft8_reorder_bank (8xDW storage + fill mask + state), instantiated once or twice per configuration.

Verification
REQ-032 Pairs idx 0..3 with in_a=0x10+2i, in_b=0x11+2i, out_ready=1 -> bins 0..7 output 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17, out_last on bin 7.
REQ-033 Indices order 3,1,0,2 same data -> identical output to REQ-032.
REQ-034 idx 1 sent twice (second in_a=0xAA) -> dup_err pulse once, bin 2 = 0xAA, no output until idx 0,2,3 arrive.
REQ-035 Two back-to-back frames, out_ready toggling 1/0 -> 16 samples correct, held stable during stalls; PINGPONG_EN: second frame accepted during drain; undefined: in_ready low until first bin 7.
REQ-036 rst_n low after bin 3 emitted -> out_valid 0 next cycle, in_ready 1; new frame outputs from bin 0.
